// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the register file and its read ports.
//   - Write-back status encoding (STAT_*), shared with the write-back stat logic.
//   - Register IDs (REG_*), the RNONE sentinel and register-file geometry.
//   - is_gpr(): true when an ID names one of the 15 architectural registers.
package y86_pkg;

    localparam int REG_ID_W = 4;
    localparam int NREG     = 15;            // architectural registers 0..14
    localparam int NID      = 2 ** REG_ID_W; // all encodable IDs, including RNONE

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [REG_ID_W-1:0] REG_RAX   = 4'h0;
    localparam logic [REG_ID_W-1:0] REG_RCX   = 4'h1;
    localparam logic [REG_ID_W-1:0] REG_RDX   = 4'h2;
    localparam logic [REG_ID_W-1:0] REG_RBX   = 4'h3;
    localparam logic [REG_ID_W-1:0] REG_RSP   = 4'h4;
    localparam logic [REG_ID_W-1:0] REG_RBP   = 4'h5;
    localparam logic [REG_ID_W-1:0] REG_RSI   = 4'h6;
    localparam logic [REG_ID_W-1:0] REG_RDI   = 4'h7;
    localparam logic [REG_ID_W-1:0] REG_R8    = 4'h8;
    localparam logic [REG_ID_W-1:0] REG_R9    = 4'h9;
    localparam logic [REG_ID_W-1:0] REG_R10   = 4'hA;
    localparam logic [REG_ID_W-1:0] REG_R11   = 4'hB;
    localparam logic [REG_ID_W-1:0] REG_R12   = 4'hC;
    localparam logic [REG_ID_W-1:0] REG_R13   = 4'hD;
    localparam logic [REG_ID_W-1:0] REG_R14   = 4'hE;
    localparam logic [REG_ID_W-1:0] REG_RNONE = 4'hF;

    // An ID addresses a real register unless it is the RNONE sentinel.
    function automatic logic is_gpr(input logic [REG_ID_W-1:0] id);
        return id != REG_RNONE;
    endfunction

endpackage

// File: rtl/y86_reg_read_port.sv
// One combinational decode read port of the Y86-64 register file.
// Ports:
//   src_id_i     register ID being read (RNONE reads as zero)
//   stored_val_i value currently held in the array for src_id_i
//   commit_e_i / dst_e_i / val_e_i  execute-path write committing this cycle
//   commit_m_i / dst_m_i / val_m_i  memory-path write committing this cycle
//   rd_val_o     read data (bypassed when BYPASS=1, stored value otherwise)
module y86_reg_read_port
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic [REG_ID_W-1:0] src_id_i,
    input  logic [DATA_W-1:0]   stored_val_i,
    input  logic                commit_e_i,
    input  logic [REG_ID_W-1:0] dst_e_i,
    input  logic [DATA_W-1:0]   val_e_i,
    input  logic                commit_m_i,
    input  logic [REG_ID_W-1:0] dst_m_i,
    input  logic [DATA_W-1:0]   val_m_i,
    output logic [DATA_W-1:0]   rd_val_o
);

    logic [DATA_W-1:0] fwd_val;

    generate
        if (BYPASS) begin : g_bypass
            // valM is checked first so a same-register E/M pair forwards the
            // value that actually lands in the array.
            always_comb begin
                fwd_val = stored_val_i;
                if (commit_m_i && (dst_m_i == src_id_i)) begin
                    fwd_val = val_m_i;
                end else if (commit_e_i && (dst_e_i == src_id_i)) begin
                    fwd_val = val_e_i;
                end
            end
        end else begin : g_plain
            logic unused_fwd;
            assign unused_fwd = ^{commit_e_i, dst_e_i, val_e_i,
                                  commit_m_i, dst_m_i, val_m_i};
            assign fwd_val = stored_val_i;
        end
    endgenerate

    assign rd_val_o = is_gpr(src_id_i) ? fwd_val : '0;

endmodule

// File: rtl/y86_reg_file.sv
// Y86-64 architectural register file: consumer end of the write-back stage.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   wb_valid_i, dstE_i/valE_i,
//   dstM_i/valM_i, stat_i              write-back record and its status
//   srcA_i/valA_o, srcB_i/valB_o       combinational decode read ports
//   dbg_sel_i/dbg_val_o                debug read of the stored array (no bypass)
//   halted_o, halt_stat_o              sticky halt flag and the status that set it
//   wr_count_o                         saturating count of committed register writes
module y86_reg_file
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_valid_i,
    input  logic [REG_ID_W-1:0] dstE_i,
    input  logic [DATA_W-1:0]   valE_i,
    input  logic [REG_ID_W-1:0] dstM_i,
    input  logic [DATA_W-1:0]   valM_i,
    input  logic [1:0]          stat_i,
    input  logic [REG_ID_W-1:0] srcA_i,
    input  logic [REG_ID_W-1:0] srcB_i,
    output logic [DATA_W-1:0]   valA_o,
    output logic [DATA_W-1:0]   valB_o,
    input  logic [REG_ID_W-1:0] dbg_sel_i,
    output logic [DATA_W-1:0]   dbg_val_o,
    output logic                halted_o,
    output logic [1:0]          halt_stat_o,
    output logic [CNT_W-1:0]    wr_count_o
);

    logic              halted_reg, halted_next;
    logic [1:0]        halt_stat_reg, halt_stat_next;
    logic [CNT_W-1:0]  wr_count_reg, wr_count_next;

    logic              wb_ok;
    logic              commit_e;
    logic              commit_m;
    logic              write_e;
    logic [1:0]        n_writes;
    logic [CNT_W:0]    count_sum;

    // Stored values indexed by every encodable ID; the RNONE slot reads zero
    // so the read ports and debug port can index without a range check.
    logic [DATA_W-1:0] stored_arr [NID];

    // ------------------------------------------------------------------
    // Commit qualification
    // ------------------------------------------------------------------
    assign wb_ok    = wb_valid_i & ~halted_reg & (stat_i == STAT_AOK);
    assign commit_e = wb_ok & is_gpr(dstE_i);
    assign commit_m = wb_ok & is_gpr(dstM_i);
    // On a same-register pair valM wins, so the E write is dropped entirely
    // and only one register is counted.
    assign write_e  = commit_e & ~(commit_m & (dstE_i == dstM_i));
    assign n_writes = {1'b0, write_e} + {1'b0, commit_m};

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NID; gi++) begin : g_slot
            if (gi < NREG) begin : g_reg
                logic [DATA_W-1:0] reg_reg;

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        reg_reg <= '0;
                    end else if (commit_m && (dstM_i == REG_ID_W'(gi))) begin
                        reg_reg <= valM_i;
                    end else if (write_e && (dstE_i == REG_ID_W'(gi))) begin
                        reg_reg <= valE_i;
                    end
                end

                assign stored_arr[gi] = reg_reg;
            end else begin : g_none
                assign stored_arr[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Halt and write-counter next state
    // ------------------------------------------------------------------
    always_comb begin
        halted_next    = halted_reg;
        halt_stat_next = halt_stat_reg;
        if (wb_valid_i && !halted_reg && (stat_i != STAT_AOK)) begin
            halted_next    = 1'b1;
            halt_stat_next = stat_i;
        end
    end

    // Add in one extra bit so a carry out means the count would wrap.
    assign count_sum = {1'b0, wr_count_reg} + (CNT_W + 1)'(n_writes);

    always_comb begin
        wr_count_next = count_sum[CNT_W-1:0];
        if (count_sum[CNT_W]) begin
            wr_count_next = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_reg    <= 1'b0;
            halt_stat_reg <= STAT_AOK;
            wr_count_reg  <= '0;
        end else begin
            halted_reg    <= halted_next;
            halt_stat_reg <= halt_stat_next;
            wr_count_reg  <= wr_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    y86_reg_read_port #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_port_a (
        .src_id_i     (srcA_i),
        .stored_val_i (stored_arr[srcA_i]),
        .commit_e_i   (write_e),
        .dst_e_i      (dstE_i),
        .val_e_i      (valE_i),
        .commit_m_i   (commit_m),
        .dst_m_i      (dstM_i),
        .val_m_i      (valM_i),
        .rd_val_o     (valA_o)
    );

    y86_reg_read_port #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_port_b (
        .src_id_i     (srcB_i),
        .stored_val_i (stored_arr[srcB_i]),
        .commit_e_i   (write_e),
        .dst_e_i      (dstE_i),
        .val_e_i      (valE_i),
        .commit_m_i   (commit_m),
        .dst_m_i      (dstM_i),
        .val_m_i      (valM_i),
        .rd_val_o     (valB_o)
    );

    assign dbg_val_o   = stored_arr[dbg_sel_i];
    assign halted_o    = halted_reg;
    assign halt_stat_o = halt_stat_reg;
    assign wr_count_o  = wr_count_reg;

endmodule

// File: tb/tb_y86_reg_file.sv
// Directed bench for y86_reg_file. Two instances share every input:
// u_dut (BYPASS=1, CNT_W=32) and u_nb (BYPASS=0, CNT_W=2, so the
// counter saturation is reachable in a few writes).
module tb_y86_reg_file;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [1:0]  stat;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dbg_sel;

    logic [63:0] val_a, val_b, dbg_val;
    logic        halted;
    logic [1:0]  halt_stat;
    logic [31:0] wr_count;

    logic [63:0] nb_val_a, nb_val_b, nb_dbg_val;
    logic        nb_halted;
    logic [1:0]  nb_halt_stat;
    logic [1:0]  nb_wr_count;

    int checks = 0;
    int errors = 0;

    y86_reg_file #(.DATA_W(64), .BYPASS(1'b1), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid),
        .dstE_i(dst_e), .valE_i(val_e), .dstM_i(dst_m), .valM_i(val_m),
        .stat_i(stat), .srcA_i(src_a), .srcB_i(src_b),
        .valA_o(val_a), .valB_o(val_b),
        .dbg_sel_i(dbg_sel), .dbg_val_o(dbg_val),
        .halted_o(halted), .halt_stat_o(halt_stat), .wr_count_o(wr_count)
    );

    y86_reg_file #(.DATA_W(64), .BYPASS(1'b0), .CNT_W(2)) u_nb (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid),
        .dstE_i(dst_e), .valE_i(val_e), .dstM_i(dst_m), .valM_i(val_m),
        .stat_i(stat), .srcA_i(src_a), .srcB_i(src_b),
        .valA_o(nb_val_a), .valB_o(nb_val_b),
        .dbg_sel_i(dbg_sel), .dbg_val_o(nb_dbg_val),
        .halted_o(nb_halted), .halt_stat_o(nb_halt_stat), .wr_count_o(nb_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_wb();
        wb_valid = 1'b0;
        dst_e    = 4'hF;
        dst_m    = 4'hF;
        val_e    = '0;
        val_m    = '0;
        stat     = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        idle_wb();
        src_a   = 4'h0;
        src_b   = 4'h0;
        dbg_sel = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_halted",   64'(halted),    64'd0);
        chk("rst_hstat",    64'(halt_stat), 64'd0);
        chk("rst_count",    64'(wr_count),  64'd0);
        chk("rst_valA",     val_a,          64'd0);
        chk("rst_nb_count", 64'(nb_wr_count), 64'd0);

        // rax <= 0x1234 via E port
        wb_valid = 1'b1; dst_e = 4'h0; val_e = 64'h1234;
        tick();
        idle_wb();
        #1;
        chk("w1_valA",  val_a,          64'h1234);
        chk("w1_count", 64'(wr_count),  64'd1);
        chk("w1_dbg",   dbg_val,        64'h1234);

        // E and M both target rsp: valM wins, one write counted
        wb_valid = 1'b1; dst_e = 4'h4; val_e = 64'hAAAA; dst_m = 4'h4; val_m = 64'hBBBB;
        src_b = 4'h4; dbg_sel = 4'h4;
        #1;
        chk("conf_byp_valB", val_b,     64'hBBBB);
        chk("conf_nb_valB",  nb_val_b,  64'h0);
        chk("conf_dbg_old",  dbg_val,   64'h0);
        tick();
        idle_wb();
        #1;
        chk("conf_dbg",   dbg_val,        64'hBBBB);
        chk("conf_count", 64'(wr_count),  64'd2);
        chk("conf_valB",  val_b,          64'hBBBB);

        // rbx <= 0x55 with same-cycle read on port A
        wb_valid = 1'b1; dst_e = 4'h3; val_e = 64'h55;
        src_a = 4'h3; dbg_sel = 4'h3;
        #1;
        chk("byp_valA",    val_a,    64'h55);
        chk("byp_dbg_old", dbg_val,  64'h0);
        chk("nb_valA_old", nb_val_a, 64'h0);
        tick();
        idle_wb();
        #1;
        chk("w3_dbg",      dbg_val,           64'h55);
        chk("w3_count",    64'(wr_count),     64'd3);
        chk("w3_nb_count", 64'(nb_wr_count),  64'd3);

        // Two distinct registers in one record: +2, narrow counter saturates
        wb_valid = 1'b1; dst_e = 4'h5; val_e = 64'h11; dst_m = 4'h6; val_m = 64'h22;
        src_a = 4'h5; src_b = 4'h6;
        #1;
        chk("pair_byp_valA", val_a, 64'h11);
        chk("pair_byp_valB", val_b, 64'h22);
        tick();
        idle_wb();
        #1;
        chk("pair_count",    64'(wr_count),    64'd5);
        chk("pair_nb_sat",   64'(nb_wr_count), 64'd3);
        chk("pair_nb_valA",  nb_val_a,         64'h11);
        chk("pair_nb_valB",  nb_val_b,         64'h22);

        // RNONE source reads zero while the bypass is active on rcx
        wb_valid = 1'b1; dst_e = 4'h1; val_e = 64'h77;
        src_a = 4'hF; src_b = 4'h1;
        #1;
        chk("rnone_valA", val_a, 64'h0);
        chk("rnone_valB", val_b, 64'h77);
        tick();
        idle_wb();
        #1;
        chk("rcx_count", 64'(wr_count), 64'd6);

        // Both destinations RNONE: nothing commits, counter holds
        wb_valid = 1'b1;
        tick();
        idle_wb();
        #1;
        chk("none_count", 64'(wr_count), 64'd6);

        // ADR status on a write to rdx: suppressed, halts
        wb_valid = 1'b1; stat = 2'b10; dst_e = 4'h2; val_e = 64'h99;
        src_a = 4'h2; dbg_sel = 4'h2;
        #1;
        chk("adr_valA", val_a, 64'h0);
        tick();
        idle_wb();
        #1;
        chk("adr_halted", 64'(halted),    64'd1);
        chk("adr_hstat",  64'(halt_stat), 64'd2);
        chk("adr_dbg",    dbg_val,        64'h0);
        chk("adr_count",  64'(wr_count),  64'd6);

        // AOK write while halted is ignored (no bypass either)
        wb_valid = 1'b1; dst_e = 4'h1; val_e = 64'hDEAD; src_b = 4'h1; dbg_sel = 4'h1;
        #1;
        chk("hlt_valB", val_b, 64'h77);
        tick();
        // A later non-AOK status must not overwrite the latched one
        idle_wb();
        wb_valid = 1'b1; stat = 2'b01;
        tick();
        idle_wb();
        #1;
        chk("hlt_dbg",   dbg_val,        64'h77);
        chk("hlt_hstat", 64'(halt_stat), 64'd2);
        chk("hlt_count", 64'(wr_count),  64'd6);

        // Reset during halt, with a competing write on the same edge
        rst = 1'b1;
        wb_valid = 1'b1; dst_e = 4'h1; val_e = 64'hFFFF;
        tick();
        rst = 1'b0;
        idle_wb();
        #1;
        chk("r2_halted",   64'(halted),      64'd0);
        chk("r2_hstat",    64'(halt_stat),   64'd0);
        chk("r2_count",    64'(wr_count),    64'd0);
        chk("r2_nb_count", 64'(nb_wr_count), 64'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            chk($sformatf("r2_reg%0d", i), dbg_val, 64'h0);
        end

        // Normal commit after reset (rdi via M port)
        wb_valid = 1'b1; dst_m = 4'h7; val_m = 64'hCAFE; dbg_sel = 4'h7;
        tick();
        idle_wb();
        #1;
        chk("post_dbg",   dbg_val,       64'hCAFE);
        chk("post_count", 64'(wr_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_reg_file.md
Name: y86_reg_file

Overview:
- Architectural register file for the Y86-64 core; it is the consumer end of the write-back interface.
- It accepts the dstE/valE and dstM/valM write-back pair plus the write-back status, and commits the values to 15 general registers.
- It serves the two combinational decode read ports, srcA and srcB.
- It latches a sticky halt when write-back reports a non-AOK status, and keeps a committed-write counter for the bench and debug.

Parameters:
- DATA_W, 64, register and value width.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- wb_valid_i  in  1  a write-back record is present this cycle.
- dstE_i  in  4  register ID for valE; 4'hF = RNONE.
- valE_i  in  DATA_W  value from the execute path.
- dstM_i  in  4  register ID for valM; 4'hF = RNONE.
- valM_i  in  DATA_W  value from the memory path.
- stat_i  in  2  write-back status: AOK / HLT / ADR / INS.
- srcA_i  in  4  read port A register ID.
- srcB_i  in  4  read port B register ID.
- valA_o  out  DATA_W  read port A data.
- valB_o  out  DATA_W  read port B data.
- dbg_sel_i  in  4  debug read register ID.
- dbg_val_o  out  DATA_W  debug read data; always the stored value, never bypassed.
- halted_o  out  1  sticky halt flag.
- halt_stat_o  out  2  status that caused the halt.
- wr_count_o  out  CNT_W  number of committed register writes.

Behaviour:
- Reset (rst_i=1 at an edge):
  - all 15 registers set to 0;
  - halted_o=0, halt_stat_o=AOK, wr_count_o=0.
  - Reset overrides every other input on the same edge.
  - A reset asserted in the middle of a halt clears the halt.
- Commit condition, per port: commit = wb_valid_i & ~halted_o & (stat_i==AOK) & (dst!=RNONE).
  - A committed value is written at the edge and is visible in the stored array the next cycle.
- Write conflict: if dstE_i==dstM_i and both ports commit, valM is written and valE is discarded (popq %rsp rule).
  - wr_count_o increments by 1 in this case, not 2.
- Write counter: wr_count_o increments by the number of distinct registers committed (0, 1 or 2). It saturates at all-ones.
- Halt detection:
  - wb_valid_i & ~halted_o & stat_i!=AOK sets halted_o=1 and halt_stat_o=stat_i at that edge.
  - The write carrying a non-AOK status is suppressed.
  - Once halted, all writes are ignored and halt_stat_o is frozen until reset.
- Reads (combinational, zero latency):
  - a source ID of RNONE returns 0.
  - BYPASS=1: if the source ID matches a committing destination this cycle, the output is that destination's value. valM is preferred over valE, matching the conflict rule. Otherwise the output is the stored value.
  - BYPASS=0: the output is always the stored value.
- wb_valid_i=0: no writes, the counter holds, stat_i is ignored.
- Status encoding: 2'b00 AOK, 2'b01 HLT, 2'b10 ADR, 2'b11 INS. This is the shared encoding used by the write-back stat logic.
- Register IDs 0..14 map to rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8..r14.

Decomposition:
- Shared package y86_pkg holds:
  - stat constants STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS;
  - REG_RNONE=4'hF and the REG_* ID constants;
  - the NREG=15 constant.
- One sub-module is natural: y86_reg_read_port, one instance per read port (A, B).
  - It takes the stored array value and both commit/dst/val triples.
  - It produces the bypassed or plain read value and handles the RNONE case.
- The write, halt and counter logic stays in the top module.

Test Plan:
- Reset, then dstE=0 (rax) with valE=64'h1234, wb_valid=1, stat=AOK → next cycle srcA=0 gives valA_o=64'h1234 and wr_count_o=1.
- Same cycle: dstE=4 with valE=64'hAAAA and dstM=4 with valM=64'hBBBB, AOK → reg4=64'hBBBB and wr_count_o increments by exactly 1. With BYPASS=1, srcB=4 in that same cycle reads 64'hBBBB.
- BYPASS=1: write reg3=64'h55 while srcA=3 in the same cycle → valA_o=64'h55 immediately, while dbg_sel=3 still shows the old value 0.
- stat=ADR with wb_valid=1 and dstE=2, valE=64'h99 → reg2 stays 0, halted_o=1, halt_stat_o=2'b10. A later AOK write to reg1 is ignored and halt_stat_o stays 2'b10.
- dstE=dstM=RNONE with valid AOK → no register changes and the counter holds. srcA=RNONE reads 0 even while the bypass is active on another register.
- Halted state, then rst_i=1 for one edge → halted_o=0, all registers read 0, wr_count_o=0, and a subsequent AOK write commits normally.
